// File: rtl/song_pkg.sv
// Shared widths, end-of-song marker and state encoding for the song reader
// and its song ROM.
package song_pkg;

   localparam int NOTE_W    = 6;
   localparam int DUR_W     = 6;
   localparam int SONG_BITS = 2;
   localparam int IDX_BITS  = 5;
   localparam int ADDR_W    = SONG_BITS + IDX_BITS;
   localparam int WORD_W    = NOTE_W + DUR_W;

   localparam logic [DUR_W-1:0]    END_MARKER = '0;
   localparam logic [IDX_BITS-1:0] LAST_IDX   = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_ROM,
      S_LOAD,
      S_WAIT_DONE,
      S_END
   } state_t;

endpackage

// File: rtl/song_rom.sv
// Registered-output song ROM: address {song, index}, word {note, duration},
// one cycle of read latency. A duration of zero marks the end of a song.
module song_rom
   import song_pkg::*;
(
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   output logic [WORD_W-1:0] dout
);

   // Song 0: 4 notes, song 1: 3 notes, song 2: 3 notes, song 3: 32 notes, no marker.
   function automatic logic [WORD_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      logic [SONG_BITS-1:0] s;
      logic [IDX_BITS-1:0]  i;
      logic [NOTE_W-1:0]    n;
      logic [DUR_W-1:0]     d;
      s = a[ADDR_W-1:IDX_BITS];
      i = a[IDX_BITS-1:0];
      n = '0;
      d = END_MARKER;
      case (s)
         2'd0: if (i < IDX_BITS'(4)) begin
            n = NOTE_W'(i) + NOTE_W'(10);
            d = DUR_W'(i) + DUR_W'(4);
         end
         2'd1: if (i < IDX_BITS'(3)) begin
            n = NOTE_W'(i) + NOTE_W'(20);
            d = DUR_W'(i) + DUR_W'(12);
         end
         2'd2: if (i < IDX_BITS'(3)) begin
            n = NOTE_W'(i) + NOTE_W'(30);
            d = DUR_W'(i) + DUR_W'(5);
         end
         default: begin
            n = NOTE_W'(i) + NOTE_W'(1);
            d = DUR_W'(i) + DUR_W'(1);
         end
      endcase
      return {n, d};
   endfunction

   // NOTE: the ROM data register has no reset; the reader only consumes it
   // one cycle after presenting an address in FETCH.
   always_ff @(posedge clk) begin
      dout <= rom_word(addr);
   end

endmodule

// File: rtl/song_reader.sv
// Steps through one song in the song ROM, handing each note to the note player
// and waiting for it to finish. Define SONG_READER_LOOP_EN to repeat songs forever.
module song_reader
   import song_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 play,
   input  logic                 new_song,
   input  logic [SONG_BITS-1:0] song,
   input  logic                 done_with_note,
   output logic [NOTE_W-1:0]    note_to_load,
   output logic [DUR_W-1:0]     duration_to_load,
   output logic                 load_new_note,
   output logic                 song_done,
   output logic                 busy
);

   state_t               state_q, state_d;
   logic [SONG_BITS-1:0] song_q, song_d;
   logic [IDX_BITS-1:0]  idx_q, idx_d;
   logic [NOTE_W-1:0]    note_q, note_d;
   logic [DUR_W-1:0]     dur_q, dur_d;

   logic [WORD_W-1:0]    rom_dout;
   logic [NOTE_W-1:0]    rom_note;
   logic [DUR_W-1:0]     rom_dur;

   song_rom u_rom (
      .clk  (clk),
      .addr ({song_q, idx_q}),
      .dout (rom_dout)
   );

   assign rom_note = rom_dout[WORD_W-1:DUR_W];
   assign rom_dur  = rom_dout[DUR_W-1:0];

   // NOTE: sequential state is updated only with non-blocking assignments so
   // every flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         song_q  <= '0;
         idx_q   <= '0;
         note_q  <= '0;
         dur_q   <= '0;
      end else begin
         state_q <= state_d;
         song_q  <= song_d;
         idx_q   <= idx_d;
         note_q  <= note_d;
         dur_q   <= dur_d;
      end
   end

   // NOTE: every next-state signal defaults to its current value before the
   // case statement, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      song_d  = song_q;
      idx_d   = idx_q;
      note_d  = note_q;
      dur_d   = dur_q;

      if (new_song) begin
         // Starting from IDLE and aborting a song in progress are the same move.
         song_d  = song;
         idx_d   = '0;
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_FETCH:
               if (play) state_d = S_WAIT_ROM;
            S_WAIT_ROM:
               if (play) begin
                  if (rom_dur == END_MARKER) begin
                     state_d = S_END;
                  end else begin
                     note_d  = rom_note;
                     dur_d   = rom_dur;
                     state_d = S_LOAD;
                  end
               end
            S_LOAD:
               state_d = S_WAIT_DONE;
            S_WAIT_DONE:
               if (play && done_with_note) begin
                  if (idx_q == LAST_IDX) begin
                     state_d = S_END;
                  end else begin
                     idx_d   = idx_q + IDX_BITS'(1);
                     state_d = S_FETCH;
                  end
               end
            S_END: begin
`ifdef SONG_READER_LOOP_EN
               // A marker at index 0 is an empty song; looping it would spin forever.
               if (idx_q == '0) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = '0;
                  state_d = S_FETCH;
               end
`else
               state_d = S_IDLE;
`endif
            end
            default:
               state_d = S_IDLE;
         endcase
      end
   end

   assign note_to_load     = note_q;
   assign duration_to_load = dur_q;
   assign load_new_note    = (state_q == S_LOAD);
   assign busy             = (state_q != S_IDLE);
`ifdef SONG_READER_LOOP_EN
   assign song_done        = (state_q == S_END) && (idx_q == '0);
`else
   assign song_done        = (state_q == S_END);
`endif

endmodule

// File: tb/tb_song_reader.sv
// Directed self-checking bench for song_reader; expected notes come from the
// hand-written ROM table (song0 10+i/4+i, song1 20+i/12+i, song2 30+i/5+i, song3 i+1/i+1).
module tb_song_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       play;
   logic       new_song;
   logic [1:0] song;
   logic       done_with_note;
   logic [5:0] note_to_load;
   logic [5:0] duration_to_load;
   logic       load_new_note;
   logic       song_done;
   logic       busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   song_reader dut (
      .clk              (clk),
      .reset            (reset),
      .play             (play),
      .new_song         (new_song),
      .song             (song),
      .done_with_note   (done_with_note),
      .note_to_load     (note_to_load),
      .duration_to_load (duration_to_load),
      .load_new_note    (load_new_note),
      .song_done        (song_done),
      .busy             (busy)
   );

   // Inputs change and outputs are sampled 1 ns after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_song(input logic [1:0] s);
      song     = s;
      new_song = 1'b1;
      tick();
      new_song = 1'b0;
   endtask

   task automatic pulse_done();
      done_with_note = 1'b1;
      tick();
      done_with_note = 1'b0;
   endtask

   task automatic wait_load(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (load_new_note === 1'b1) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      total_cnt++;
      if ({busy, load_new_note, song_done, note_to_load, duration_to_load} !== 15'd0)
         $display("FAIL reset_outputs: got busy=%b load=%b done=%b note=%0d dur=%0d, want all 0",
                  busy, load_new_note, song_done, note_to_load, duration_to_load);
      else pass_cnt++;
      reset = 1'b0;
      tick();
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b want 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_first_note();
      play = 1'b1;
      start_song(2'd1);
      total_cnt++;
      if ({busy, load_new_note} !== 2'b10)
         $display("FAIL first_n1: busy=%b load=%b want busy=1 load=0", busy, load_new_note);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (load_new_note !== 1'b0) $display("FAIL first_n2: load=%b want 0", load_new_note);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (load_new_note !== 1'b1) $display("FAIL first_n3: load=%b want 1", load_new_note);
      else pass_cnt++;
      total_cnt++;
      if ({note_to_load, duration_to_load} !== {6'd20, 6'd12})
         $display("FAIL first_data: note=%0d dur=%0d want 20/12", note_to_load, duration_to_load);
      else pass_cnt++;
   endtask

   task automatic test_next_note();
      tick();
      total_cnt++;
      if (load_new_note !== 1'b0) $display("FAIL load_pulse_width: load=%b want 0", load_new_note);
      else pass_cnt++;
      pulse_done();
      tick();
      total_cnt++;
      if (load_new_note !== 1'b0) $display("FAIL next_m2: load=%b want 0", load_new_note);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({load_new_note, note_to_load, duration_to_load} !== {1'b1, 6'd21, 6'd13})
         $display("FAIL next_m3: load=%b note=%0d dur=%0d want 1/21/13",
                  load_new_note, note_to_load, duration_to_load);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (load_new_note !== 1'b0) $display("FAIL next_pulse_end: load=%b want 0", load_new_note);
      else pass_cnt++;
   endtask

   task automatic test_pause();
      bit seen;
      play = 1'b0;
      pulse_done();
      tick();
      tick();
      total_cnt++;
      if ({busy, load_new_note, note_to_load, duration_to_load} !== {1'b1, 1'b0, 6'd21, 6'd13})
         $display("FAIL pause_hold: busy=%b load=%b note=%0d dur=%0d want 1/0/21/13",
                  busy, load_new_note, note_to_load, duration_to_load);
      else pass_cnt++;
      play = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         tick();
         if (load_new_note === 1'b1) seen = 1'b1;
      end
      total_cnt++;
      if (seen !== 1'b0) $display("FAIL pause_ignored_done: load seen=%b want 0", seen);
      else pass_cnt++;
      pulse_done();
      tick();
      tick();
      total_cnt++;
      if ({load_new_note, note_to_load, duration_to_load} !== {1'b1, 6'd22, 6'd14})
         $display("FAIL resume_load: load=%b note=%0d dur=%0d want 1/22/14",
                  load_new_note, note_to_load, duration_to_load);
      else pass_cnt++;
   endtask

   task automatic test_song_end();
      bit         ok;
      logic [11:0] exp;
      play = 1'b1;
      start_song(2'd2);
      for (int i = 0; i < 3; i++) begin
         wait_load(ok);
         total_cnt++;
         if (!ok) $display("FAIL end_load_timeout: note %0d never loaded", i);
         else pass_cnt++;
         exp = {6'(30 + i), 6'(5 + i)};
         total_cnt++;
         if ({note_to_load, duration_to_load} !== exp)
            $display("FAIL end_note_data: idx %0d got %0d/%0d want %0d/%0d", i,
                     note_to_load, duration_to_load, exp[11:6], exp[5:0]);
         else pass_cnt++;
         tick();
         pulse_done();
      end
      tick();
      total_cnt++;
      if (song_done !== 1'b0) $display("FAIL end_early: song_done=%b want 0 at M+2", song_done);
      else pass_cnt++;
      tick();
`ifdef SONG_READER_LOOP_EN
      total_cnt++;
      if (song_done !== 1'b0) $display("FAIL loop_no_done: song_done=%b want 0", song_done);
      else pass_cnt++;
      tick();
      tick();
      tick();
      total_cnt++;
      if ({load_new_note, note_to_load, duration_to_load} !== {1'b1, 6'd30, 6'd5})
         $display("FAIL loop_reload: load=%b note=%0d dur=%0d want 1/30/5",
                  load_new_note, note_to_load, duration_to_load);
      else pass_cnt++;
`else
      total_cnt++;
      if ({song_done, busy} !== 2'b11)
         $display("FAIL end_pulse: song_done=%b busy=%b want 1/1", song_done, busy);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({song_done, busy, note_to_load, duration_to_load} !== {2'b00, 6'd32, 6'd7})
         $display("FAIL end_idle: song_done=%b busy=%b note=%0d dur=%0d want 0/0/32/7",
                  song_done, busy, note_to_load, duration_to_load);
      else pass_cnt++;
`endif
   endtask

   task automatic test_abort_and_reset();
      bit ok;
      play = 1'b1;
      start_song(2'd0);
      wait_load(ok);
      total_cnt++;
      if (!ok || {note_to_load, duration_to_load} !== {6'd10, 6'd4})
         $display("FAIL abort_first: ok=%b note=%0d dur=%0d want 1/10/4",
                  ok, note_to_load, duration_to_load);
      else pass_cnt++;
      tick();
      start_song(2'd3);
      total_cnt++;
      if ({song_done, busy, note_to_load, duration_to_load} !== {2'b01, 6'd10, 6'd4})
         $display("FAIL abort_hold: song_done=%b busy=%b note=%0d dur=%0d want 0/1/10/4",
                  song_done, busy, note_to_load, duration_to_load);
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if ({load_new_note, note_to_load, duration_to_load} !== {1'b1, 6'd1, 6'd1})
         $display("FAIL abort_load: load=%b note=%0d dur=%0d want 1/1/1",
                  load_new_note, note_to_load, duration_to_load);
      else pass_cnt++;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total_cnt++;
      if ({busy, load_new_note, song_done, note_to_load, duration_to_load} !== 15'd0)
         $display("FAIL midsong_reset: busy=%b load=%b done=%b note=%0d dur=%0d want all 0",
                  busy, load_new_note, song_done, note_to_load, duration_to_load);
      else pass_cnt++;
   endtask

   task automatic test_full_song();
      bit ok;
      play = 1'b1;
      start_song(2'd3);
      for (int i = 0; i < 32; i++) begin
         wait_load(ok);
         total_cnt++;
         if (!ok || {note_to_load, duration_to_load} !== {6'(i + 1), 6'(i + 1)})
            $display("FAIL full_note: idx %0d ok=%b note=%0d dur=%0d want %0d/%0d",
                     i, ok, note_to_load, duration_to_load, i + 1, i + 1);
         else pass_cnt++;
         tick();
         pulse_done();
      end
`ifdef SONG_READER_LOOP_EN
      total_cnt++;
      if (song_done !== 1'b0) $display("FAIL full_loop_no_done: song_done=%b want 0", song_done);
      else pass_cnt++;
      tick();
      tick();
      tick();
      total_cnt++;
      if ({song_done, load_new_note, note_to_load, duration_to_load} !== {2'b01, 6'd1, 6'd1})
         $display("FAIL full_loop_reload: done=%b load=%b note=%0d dur=%0d want 0/1/1/1",
                  song_done, load_new_note, note_to_load, duration_to_load);
      else pass_cnt++;
`else
      total_cnt++;
      if ({song_done, busy} !== 2'b11)
         $display("FAIL full_end_pulse: song_done=%b busy=%b want 1/1", song_done, busy);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({song_done, busy} !== 2'b00)
         $display("FAIL full_end_idle: song_done=%b busy=%b want 0/0", song_done, busy);
      else pass_cnt++;
`endif
   endtask

   initial begin
      reset          = 1'b1;
      play           = 1'b0;
      new_song       = 1'b0;
      song           = 2'd0;
      done_with_note = 1'b0;
      test_reset();
      test_first_note();
      test_next_note();
      test_pause();
      test_song_end();
      test_abort_and_reset();
      test_full_song();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
